// File: rtl/imu_frame_if.sv
// Byte-stream input and assembled-sample output bundle for imu_frame_assembler.
// master = upstream sequencer/SPI side plus consumer, slave = the assembler.
interface imu_frame_if;
  logic               frame_start;
  logic               read_ready;
  logic [7:0]         read_data;
  logic signed [15:0] gyro_x;
  logic signed [15:0] gyro_y;
  logic signed [15:0] gyro_z;
  logic signed [15:0] accel_x;
  logic signed [15:0] accel_y;
  logic signed [15:0] accel_z;
  logic               sample_valid;
  logic               frame_error;
  logic [7:0]         error_count;

  modport master (
    output frame_start, read_ready, read_data,
    input  gyro_x, gyro_y, gyro_z, accel_x, accel_y, accel_z,
    input  sample_valid, frame_error, error_count
  );

  modport slave (
    input  frame_start, read_ready, read_data,
    output gyro_x, gyro_y, gyro_z, accel_x, accel_y, accel_z,
    output sample_valid, frame_error, error_count
  );
endinterface

// File: rtl/imu_frame_assembler.sv
// Assembles a 12-byte little-endian gyro+accel burst into six signed samples.
// Define IMU_FRAME_TIMEOUT_EN to abandon frames after TIMEOUT_CYCLES idle clocks.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no frame open; stray bytes are ignored
// COLLECT | frame open; bytes land in shadow[index] until byte 11
module imu_frame_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  imu_frame_if.slave  bus
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t     state;
  logic [3:0] index;
  logic [7:0] shadow [0:10];
`ifdef IMU_FRAME_TIMEOUT_EN
  logic [15:0] timer;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      index            <= 4'd0;
      for (int i = 0; i < 11; i++) shadow[i] <= 8'h00;
      bus.gyro_x       <= '0;
      bus.gyro_y       <= '0;
      bus.gyro_z       <= '0;
      bus.accel_x      <= '0;
      bus.accel_y      <= '0;
      bus.accel_z      <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_error  <= 1'b0;
      bus.error_count  <= 8'd0;
`ifdef IMU_FRAME_TIMEOUT_EN
      timer            <= 16'd0;
`endif
    end else begin
      bus.sample_valid <= 1'b0;
      bus.frame_error  <= 1'b0;
      if (bus.frame_start) begin
        // A coincident byte belongs to the new frame; only a non-empty old frame counts as an error.
        if (state == COLLECT && index != 4'd0) begin
          bus.frame_error <= 1'b1;
          if (bus.error_count != 8'hFF) bus.error_count <= bus.error_count + 8'd1;
        end
        state <= COLLECT;
`ifdef IMU_FRAME_TIMEOUT_EN
        timer <= 16'd0;
`endif
        if (bus.read_ready) begin
          shadow[0] <= bus.read_data;
          index     <= 4'd1;
        end else begin
          index     <= 4'd0;
        end
      end else if (state == COLLECT) begin
        if (bus.read_ready) begin
`ifdef IMU_FRAME_TIMEOUT_EN
          timer <= 16'd0;
`endif
          if (index == 4'd11) begin
            bus.gyro_x       <= {shadow[1], shadow[0]};
            bus.gyro_y       <= {shadow[3], shadow[2]};
            bus.gyro_z       <= {shadow[5], shadow[4]};
            bus.accel_x      <= {shadow[7], shadow[6]};
            bus.accel_y      <= {shadow[9], shadow[8]};
            bus.accel_z      <= {bus.read_data, shadow[10]};
            bus.sample_valid <= 1'b1;
            state            <= IDLE;
            index            <= 4'd0;
          end else begin
            shadow[index] <= bus.read_data;
            index         <= index + 4'd1;
          end
        end
`ifdef IMU_FRAME_TIMEOUT_EN
        // Expiry lands on the TIMEOUT_CYCLES-th consecutive idle clock; a byte on that clock wins.
        else if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
          bus.frame_error <= 1'b1;
          if (bus.error_count != 8'hFF) bus.error_count <= bus.error_count + 8'd1;
          state <= IDLE;
          index <= 4'd0;
          timer <= 16'd0;
        end else begin
          timer <= timer + 16'd1;
        end
`endif
      end
    end
  end

endmodule

// File: doc/imu_frame_assembler.md
# imu_frame_assembler

Byte-to-sample assembler sitting directly downstream of the SPI master in the attitude-estimation datapath. Consumes the `read_ready`/`read_data` byte stream produced by the SPI master during a combined gyroscope-then-accelerometer burst, assembles twelve little-endian bytes into six signed 16-bit axis samples, and presents them atomically with a one-cycle valid strobe to the estimator. Detects truncated frames by restart or inter-byte timeout and reports them.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 4096: max idle clocks between consecutive bytes inside a frame; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `frame_start`  in  1  one-cycle pulse from the sequencer: the next accepted byte is byte 0 of a new frame.
- `read_ready`  in  1  byte strobe from the SPI master, one cycle per byte.
- `read_data`  in  8  byte accompanying `read_ready`.
- `gyro_x`, `gyro_y`, `gyro_z`  out  16 each  signed gyroscope samples.
- `accel_x`, `accel_y`, `accel_z`  out  16 each  signed accelerometer samples.
- `sample_valid`  out  1  one-cycle pulse; all six sample outputs updated this cycle.
- `frame_error`  out  1  one-cycle pulse; a partial frame was abandoned.
- `error_count`  out  8  saturating count of abandoned frames.

## Operation
- Byte order within a frame: index 0..11 = GX_L, GX_H, GY_L, GY_H, GZ_L, GZ_H, AX_L, AX_H, AY_L, AY_H, AZ_L, AZ_H.
- States: IDLE, COLLECT.
- IDLE: `read_ready` bytes ignored (no error). `frame_start` -> COLLECT, index = 0.
- COLLECT: each `read_ready` writes `read_data` to shadow register slot [index], index increments. On index 11 accepted: shadow copied to all six outputs, `sample_valid` pulses, state -> IDLE.
- Sample outputs change only on `sample_valid`; hold between frames; partial frames never leak to outputs.
- `frame_start` in COLLECT with index != 0: abandon partial frame, `frame_error` pulses, `error_count` increments, restart at index 0. With index == 0: silent restart, no error.
- `frame_start` and `read_ready` in same cycle (either state): byte is taken as index 0 of the new frame; index becomes 1; any abandonment error applies to the old frame.
- `error_count` saturates at 255; cleared only by reset.

## Timing
- Reset values: all sample outputs 0x0000, `sample_valid` 0, `frame_error` 0, `error_count` 0, state IDLE, index 0, timeout counter 0.
- Latency: `sample_valid` and new sample values registered in the cycle after the clock edge sampling the 12th `read_ready` (1 cycle).
- `frame_error` registered one cycle after the causing `frame_start` or timeout expiry.
- Back-to-back bytes (`read_ready` every cycle) fully supported; full frame plus immediate `frame_start` on the `sample_valid` cycle loses nothing.
- Reset asserted mid-frame: partial frame discarded silently, no error counted; outputs return to reset values.

## Configuration
- `IMU_FRAME_TIMEOUT_EN` defined: in COLLECT a 16-bit counter clears on every accepted byte and increments otherwise; when it reaches `TIMEOUT_CYCLES` with no byte, frame abandoned (`frame_error` pulse, `error_count` increment, state -> IDLE). A byte arriving on the expiry cycle is accepted and cancels the timeout.
- Not defined: no counter; COLLECT waits indefinitely, abandonment only via `frame_start`.

## Test plan
- Reset, `frame_start`, bytes 0x34,0x12,0x78,0x56,0xBC,0x9A,0x01,0x80,0xFF,0xFF,0x00,0x00 back-to-back -> one cycle after last byte: `sample_valid`=1 one cycle, gyro 0x1234/0x5678/0x9ABC, accel 0x8001/0xFFFF/0x0000, `frame_error` never asserted.
- Bytes with no preceding `frame_start` -> outputs stay 0x0000, no `sample_valid`, `error_count`=0.
- `frame_start`, 5 bytes, `frame_start` coincident with byte 0x11, 11 more bytes -> one `frame_error` pulse, `error_count`=1, GX_L=0x11 in delivered frame.
- With `IMU_FRAME_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: `frame_start`, 3 bytes, 16 idle cycles -> `frame_error` pulse, state IDLE; later bytes ignored until next `frame_start`; repeat with byte on cycle 16 -> no error.
- 300 abandoned frames -> `error_count` holds 255.
- Reset deasserted-then-asserted after 7 bytes -> all outputs 0, `error_count`=0; next full frame assembles correctly.
